// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared issue-stage definitions: monitor states, error bit positions, FU classes
package sys_defs;

  typedef enum logic [1:0] {
    MON_OFF   = 2'b00,
    MON_RUN   = 2'b01,
    MON_FAULT = 2'b10
  } ISSUE_MON_STATE;

  localparam int ERR_NOT_READY = 0;
  localparam int ERR_OVERSUB   = 1;
  localparam int ERR_STARVE    = 2;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_BRANCH = 2'd2,
    FU_LDST   = 2'd3
  } FU_CLASS;

endpackage

// File: rtl/issue_mon_age_ctr.sv
// rtl/issue_mon_age_ctr.sv - saturating per-entry starvation age counter with one-shot starve pulse
module issue_mon_age_ctr #(
  parameter int STARVE_LIMIT = 64,
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic flush,
  input  logic eligible,
  output logic starve
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age;

  // Fires only on the LIMIT-1 -> LIMIT step, so a saturated age stays quiet.
  assign starve = active && eligible && !flush && (age == LIMIT - 1'b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age <= '0;
    end else if (!active || flush || !eligible) begin
      age <= '0;
    end else if (age != LIMIT) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/issue_monitor.sv
// rtl/issue_monitor.sv - issue-stage run-time checker; optional CDB forwarding via ISSUE_MON_CDB_FWD_EN
module issue_monitor
  import sys_defs::*;
#(
  parameter int RS_SZ         = 16,
  parameter int NUM_CLASSES   = 4,
  parameter int MAX_PER_CLASS = 4,
  parameter int STARVE_LIMIT  = 64,
  parameter int ERR_CNT_W     = 16,
`ifdef ISSUE_MON_CDB_FWD_EN
  parameter int CDB_N         = 2,
  parameter int PHYS_REG_IDX  = 6,
`endif
  localparam int IDX_W   = $clog2(RS_SZ),
  localparam int CLASS_W = $clog2(NUM_CLASSES),
  localparam int FREE_W  = $clog2(MAX_PER_CLASS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          clear_err,
  input  logic [RS_SZ-1:0]              rs_valid,
  input  logic [RS_SZ-1:0]              rs_src1_ready,
  input  logic [RS_SZ-1:0]              rs_src2_ready,
  input  logic [RS_SZ*CLASS_W-1:0]      rs_class,
  input  logic [RS_SZ-1:0]              rs_issuing,
  input  logic [NUM_CLASSES*FREE_W-1:0] fu_free,
`ifdef ISSUE_MON_CDB_FWD_EN
  input  logic [CDB_N-1:0]              cdb_valid,
  input  logic [CDB_N*PHYS_REG_IDX-1:0] cdb_tag,
  input  logic [RS_SZ*PHYS_REG_IDX-1:0] rs_src1_tag,
  input  logic [RS_SZ*PHYS_REG_IDX-1:0] rs_src2_tag,
`endif
  output logic                          err_valid,
  output logic [2:0]                    err_code,
  output logic [IDX_W-1:0]              err_index,
  output logic [CLASS_W-1:0]            err_class,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [1:0]                    mon_state
);

  ISSUE_MON_STATE state_q, state_d;

  logic                   active;
  logic [RS_SZ-1:0]       src1_ok, src2_ok, entry_ok, not_ready, eligible, starve;
  logic [NUM_CLASSES-1:0] oversub;
  logic [2:0]             code_d;
  logic                   violation;
  logic [IDX_W-1:0]       index_d;
  logic [CLASS_W-1:0]     class_d;

  assign active = (state_q != MON_OFF);

`ifdef ISSUE_MON_CDB_FWD_EN
  // A tag broadcast on the CDB this cycle wakes the operand as if already ready.
  always_comb begin
    src1_ok = rs_src1_ready;
    src2_ok = rs_src2_ready;
    for (int i = 0; i < RS_SZ; i++) begin
      for (int k = 0; k < CDB_N; k++) begin
        if (cdb_valid[k] && cdb_tag[k*PHYS_REG_IDX +: PHYS_REG_IDX] == rs_src1_tag[i*PHYS_REG_IDX +: PHYS_REG_IDX])
          src1_ok[i] = 1'b1;
        if (cdb_valid[k] && cdb_tag[k*PHYS_REG_IDX +: PHYS_REG_IDX] == rs_src2_tag[i*PHYS_REG_IDX +: PHYS_REG_IDX])
          src2_ok[i] = 1'b1;
      end
    end
  end
`else
  assign src1_ok = rs_src1_ready;
  assign src2_ok = rs_src2_ready;
`endif

  assign entry_ok  = rs_valid & src1_ok & src2_ok;
  assign not_ready = active ? (rs_issuing & ~entry_ok) : '0;
  assign eligible  = entry_ok & ~rs_issuing;

  for (genvar g = 0; g < RS_SZ; g++) begin : g_age
    issue_mon_age_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
      .clock   (clock),
      .reset   (reset),
      .active  (active),
      .flush   (flush),
      .eligible(eligible[g]),
      .starve  (starve[g])
    );
  end

  always_comb begin
    int cnt;
    oversub = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      cnt = 0;
      for (int i = 0; i < RS_SZ; i++) begin
        if (rs_issuing[i] && rs_class[i*CLASS_W +: CLASS_W] == CLASS_W'(c))
          cnt = cnt + 1;
      end
      oversub[c] = active && (cnt > int'(fu_free[c*FREE_W +: FREE_W]));
    end
  end

  // Descending scans leave the lowest hit; not-ready overrides starvation.
  always_comb begin
    index_d = '0;
    class_d = '0;
    for (int i = RS_SZ - 1; i >= 0; i--)
      if (starve[i]) index_d = IDX_W'(i);
    for (int i = RS_SZ - 1; i >= 0; i--)
      if (not_ready[i]) index_d = IDX_W'(i);
    for (int c = NUM_CLASSES - 1; c >= 0; c--)
      if (oversub[c]) class_d = CLASS_W'(c);
  end

  always_comb begin
    code_d                = '0;
    code_d[ERR_NOT_READY] = |not_ready;
    code_d[ERR_OVERSUB]   = |oversub;
    code_d[ERR_STARVE]    = |starve;
  end

  assign violation = |code_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MON_OFF:   if (enable) state_d = MON_RUN;
      MON_RUN:   if (violation) state_d = MON_FAULT;
      MON_FAULT: if (clear_err && !violation) state_d = MON_RUN;
      default:   state_d = MON_OFF;
    endcase
    if (!enable) state_d = MON_OFF;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MON_OFF;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_code  <= '0;
      err_index <= '0;
      err_class <= '0;
      err_count <= '0;
    end else begin
      err_valid <= violation;
      if (violation) begin
        err_code  <= code_d;
        err_index <= index_d;
        err_class <= class_d;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign mon_state = state_q;

endmodule

// File: tb/tb_issue_monitor.sv
// tb/tb_issue_monitor.sv - scoreboard bench for issue_monitor; CDB cases follow ISSUE_MON_CDB_FWD_EN
module tb_issue_monitor;

  localparam int RS_SZ = 16;
  localparam int NCL   = 4;
  localparam int LIMIT = 64;
  localparam int TW    = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, flush, clear_err;
  logic [15:0] rs_valid, rs_src1_ready, rs_src2_ready, rs_issuing;
  logic [31:0] rs_class;
  logic [11:0] fu_free;
`ifdef ISSUE_MON_CDB_FWD_EN
  logic [1:0]      cdb_valid;
  logic [2*TW-1:0] cdb_tag;
  logic [RS_SZ*TW-1:0] rs_src1_tag, rs_src2_tag;
`endif
  logic        err_valid;
  logic [2:0]  err_code;
  logic [3:0]  err_index;
  logic [1:0]  err_class;
  logic [15:0] err_count;
  logic [1:0]  mon_state;

  issue_monitor dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .clear_err(clear_err),
    .rs_valid(rs_valid), .rs_src1_ready(rs_src1_ready), .rs_src2_ready(rs_src2_ready),
    .rs_class(rs_class), .rs_issuing(rs_issuing), .fu_free(fu_free),
`ifdef ISSUE_MON_CDB_FWD_EN
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rs_src1_tag(rs_src1_tag), .rs_src2_tag(rs_src2_tag),
`endif
    .err_valid(err_valid), .err_code(err_code), .err_index(err_index),
    .err_class(err_class), .err_count(err_count), .mon_state(mon_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [2:0]  code;
    logic [3:0]  idx;
    logic [1:0]  cls;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   m_state;
  int   m_age[RS_SZ];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m = '{v: 1'b0, code: 3'd0, idx: 4'd0, cls: 2'd0, cnt: 16'd0, st: 2'd0};
    m_state = 0;
    for (int i = 0; i < RS_SZ; i++) m_age[i] = 0;
  endtask

  function automatic bit fwd(input int i, input bit second);
    bit hit = 1'b0;
`ifdef ISSUE_MON_CDB_FWD_EN
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TW +: TW] == (second ? rs_src2_tag[i*TW +: TW] : rs_src1_tag[i*TW +: TW]))
        hit = 1'b1;
    end
`else
    hit = 1'b0;
`endif
    return hit;
  endfunction

  // Reference model: predicts the registered outputs after the coming edge.
  task automatic model_step();
    bit act, ok, elig, viol;
    bit [15:0] nr, st;
    bit [3:0]  ov;
    int cnt, idx, cls;
    act = (m_state != 0);
    nr = '0; st = '0; ov = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      ok   = rs_valid[i] && (rs_src1_ready[i] || fwd(i, 1'b0)) && (rs_src2_ready[i] || fwd(i, 1'b1));
      elig = ok && !rs_issuing[i];
      nr[i] = act && rs_issuing[i] && !ok;
      st[i] = act && elig && !flush && (m_age[i] == LIMIT - 1);
      if (!act || flush || !elig) m_age[i] = 0;
      else if (m_age[i] < LIMIT)  m_age[i] = m_age[i] + 1;
    end
    for (int c = 0; c < NCL; c++) begin
      cnt = 0;
      for (int i = 0; i < RS_SZ; i++)
        if (rs_issuing[i] && rs_class[i*2 +: 2] == c) cnt++;
      ov[c] = act && (cnt > fu_free[c*3 +: 3]);
    end
    viol = (nr != 0) || (st != 0) || (ov != 0);
    idx = -1;
    for (int i = 0; i < RS_SZ; i++) if (idx < 0 && nr[i]) idx = i;
    for (int i = 0; i < RS_SZ; i++) if (idx < 0 && st[i]) idx = i;
    cls = -1;
    for (int c = 0; c < NCL; c++) if (cls < 0 && ov[c]) cls = c;
    m.v = viol;
    if (viol) begin
      m.code = {st != 0, ov != 0, nr != 0};
      m.idx  = (idx < 0) ? 4'd0 : 4'(idx);
      m.cls  = (cls < 0) ? 2'd0 : 2'(cls);
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end
    if (!enable)                           m_state = 0;
    else if (m_state == 0)                 m_state = 1;
    else if (m_state == 1 && viol)         m_state = 2;
    else if (m_state == 2 && clear_err && !viol) m_state = 1;
    m.st = 2'(m_state);
    sb.push_back(m);
  endtask

  task automatic step(input bit chk);
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    e = sb.pop_front();
    if (chk) begin
      check("err_valid", 32'(err_valid), 32'(e.v));
      check("err_code",  32'(err_code),  32'(e.code));
      check("err_index", 32'(err_index), 32'(e.idx));
      check("err_class", 32'(err_class), 32'(e.cls));
      check("err_count", 32'(err_count), 32'(e.cnt));
      check("mon_state", 32'(mon_state), 32'(e.st));
    end
  endtask

  task automatic idle_inputs();
    flush = 0; clear_err = 0;
    rs_valid = '0; rs_src1_ready = '0; rs_src2_ready = '0; rs_issuing = '0;
    rs_class = '0; fu_free = {3'd4, 3'd4, 3'd4, 3'd4};
`ifdef ISSUE_MON_CDB_FWD_EN
    cdb_valid = '0; cdb_tag = '0; rs_src1_tag = '0; rs_src2_tag = '0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(err_valid), 32'd0);
    check({tag, "_code"},  32'(err_code),  32'd0);
    check({tag, "_index"}, 32'(err_index), 32'd0);
    check({tag, "_count"}, 32'(err_count), 32'd0);
    check({tag, "_state"}, 32'(mon_state), 32'd0);
  endtask

  initial begin
    int seen_at;
    idle_inputs();
    enable = 0;
    reset = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    #3 reset = 1;
    #2;

    enable = 1;
    step(1);
    check("enter_run", 32'(mon_state), 32'd1);

    // Not-ready issue of entry 3
    rs_valid[3] = 1; rs_src1_ready[3] = 1; rs_src2_ready[3] = 0; rs_issuing[3] = 1;
    step(1);
    check("nr_valid", 32'(err_valid), 32'd1);
    check("nr_code",  32'(err_code),  32'd1);
    check("nr_index", 32'(err_index), 32'd3);
    check("nr_count", 32'(err_count), 32'd1);
    check("nr_state", 32'(mon_state), 32'd2);
    idle_inputs();
    step(1);
    check("pulse_once", 32'(err_valid), 32'd0);
    check("code_hold",  32'(err_code),  32'd1);

    // Fault clear with clean inputs, then clear racing a new violation
    clear_err = 1;
    step(1);
    check("clear_run", 32'(mon_state), 32'd1);
    rs_issuing[9] = 1;
    step(1);
    rs_issuing = '0; clear_err = 1;
    rs_valid[0] = 1; rs_issuing[0] = 1;
    step(1);
    check("clear_race_state", 32'(mon_state), 32'd2);
    check("clear_race_count", 32'(err_count), 32'd3);
    idle_inputs();
    clear_err = 1;
    step(1);

    // Oversubscription of class 1
    for (int i = 6; i <= 8; i++) begin
      rs_valid[i] = 1; rs_src1_ready[i] = 1; rs_src2_ready[i] = 1; rs_issuing[i] = 1;
      rs_class[i*2 +: 2] = 2'd1;
    end
    fu_free[3 +: 3] = 3'd2;
    step(1);
    check("os_code",  32'(err_code),  32'd2);
    check("os_class", 32'(err_class), 32'd1);
    fu_free[3 +: 3] = 3'd3;
    step(1);
    check("os_equal_ok", 32'(err_valid), 32'd0);
    idle_inputs();
    clear_err = 1;
    step(1);
    clear_err = 0;

    // Entry 2 builds age 30, then an asynchronous reset mid-cycle
    rs_valid[2] = 1; rs_src1_ready[2] = 1; rs_src2_ready[2] = 1;
    repeat (30) step(1);
    #2 reset = 0;
    model_clear();
    #1;
    check_all_zero("midrst");
    #2 reset = 1;
    #3;
    seen_at = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (err_valid && seen_at == 0) seen_at = k;
    end
    check("rst_starve_cycle", 32'(seen_at), 32'd65);
    check("rst_starve_index", 32'(err_index), 32'd2);

    // Entry 5 starves; flush at cycle 40 restarts its age
    idle_inputs();
    clear_err = 1;
    step(1);
    clear_err = 0;
    rs_valid[5] = 1; rs_src1_ready[5] = 1; rs_src2_ready[5] = 1;
    seen_at = 0;
    for (int k = 1; k <= 140; k++) begin
      flush = (k == 40);
      step(1);
      if (err_valid && seen_at == 0) seen_at = k;
    end
    flush = 0;
    check("starve_cycle", 32'(seen_at), 32'd104);
    check("starve_code",  32'(err_code), 32'd4);
    check("starve_index", 32'(err_index), 32'd5);

    // CDB wakeup of source 2
    idle_inputs();
    clear_err = 1;
    step(1);
    clear_err = 0;
    rs_valid[4] = 1; rs_src1_ready[4] = 1; rs_src2_ready[4] = 0; rs_issuing[4] = 1;
`ifdef ISSUE_MON_CDB_FWD_EN
    rs_src2_tag[4*TW +: TW] = 6'd17;
    cdb_valid[0] = 1; cdb_tag[0 +: TW] = 6'd17;
    step(1);
    check("cdb_fwd_clean", 32'(err_valid), 32'd0);
`else
    step(1);
    check("cdb_off_code", 32'(err_code), 32'd1);
`endif

    // Saturate the error counter
    idle_inputs();
    rs_issuing[1] = 1;
    for (int k = 0; k < 65540; k++) step(0);
    step(1);
    check("count_sat", 32'(err_count), 32'hFFFF);

    idle_inputs();
    enable = 0;
    step(1);
    check("disable_off", 32'(mon_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/issue_monitor.md
Name: issue_monitor

Overview:
- Synthesizable, parametrised run-time checker for the issue stage of the R10K-style out-of-order core; sits beside the RS/issue logic and observes it without driving it.
- Checks three things each cycle:
  - every issued RS entry has both source operands ready;
  - the number of issues per FU class does not exceed that class's free units;
  - no ready entry starves for more than a bounded number of cycles.
- Reports violations through registered error outputs, a sticky fault state machine and a saturating error counter. Usable in simulation and on FPGA.

Parameters:
- RS_SZ, 16, number of RS entries observed
- NUM_CLASSES, 4, FU classes (ALU, MULT, BRANCH, LDST)
- MAX_PER_CLASS, 4, maximum FUs per class
- STARVE_LIMIT, 64, consecutive ready-not-issued cycles that trigger a starvation error
- ERR_CNT_W, 16, error counter width
- Derived: IDX_W=$clog2(RS_SZ), CLASS_W=$clog2(NUM_CLASSES), FREE_W=$clog2(MAX_PER_CLASS+1), AGE_W=$clog2(STARVE_LIMIT+1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  checking enabled
- flush  in  1  mispredict squash; clears all starvation ages
- clear_err  in  1  acknowledge fault; FAULT->RUN
- rs_valid  in  RS_SZ  entry occupied
- rs_src1_ready  in  RS_SZ  source 1 ready bit
- rs_src2_ready  in  RS_SZ  source 2 ready bit
- rs_class  in  RS_SZ*CLASS_W  FU class of each entry
- rs_issuing  in  RS_SZ  entry selected for issue this cycle
- fu_free  in  NUM_CLASSES*FREE_W  free FU count per class
- err_valid  out  1  pulse: at least one violation was detected in the previous cycle
- err_code  out  3  bit0 not-ready issue, bit1 oversubscription, bit2 starvation
- err_index  out  IDX_W  lowest offending RS index (not-ready takes precedence over starvation)
- err_class  out  CLASS_W  lowest oversubscribed class
- err_count  out  ERR_CNT_W  saturating count of err_valid cycles
- mon_state  out  2  00 OFF, 01 RUN, 10 FAULT

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0 and mon_state=OFF;
  - all starvation ages 0;
  - takes effect mid-operation immediately, with no pending error surviving.
- FSM:
  - OFF->RUN when enable=1.
  - RUN->FAULT on any violation.
  - FAULT->RUN on clear_err, unless a violation occurs in the same cycle; then it stays FAULT.
  - RUN or FAULT->OFF when enable=0.
  - Checks are evaluated in RUN and FAULT only; in OFF, ages are held at 0 and err_valid=0.
- Latency: a violation on inputs in cycle t appears on err_* outputs at edge t+1. err_code, err_index and err_class hold their last values until the next error; err_valid is high for one cycle only.
- Not-ready check: rs_issuing[i] && !(rs_valid[i] && src1_ok[i] && src2_ok[i]). Issuing an invalid entry is also flagged.
- Oversubscription check: popcount over i of (rs_issuing[i] && rs_class[i]==c) > fu_free[c]. An equal count is legal.
- Starvation ages, per entry:
  - age increments when valid, both sources ready and not issuing;
  - age resets to 0 when the entry is not valid, not ready, issuing, or flush=1;
  - age saturates at STARVE_LIMIT;
  - the error is raised once, in the cycle the age transitions to STARVE_LIMIT, and is not re-raised while the age is saturated.
  - flush has priority over the increment.
- Multiple violations in one cycle set multiple err_code bits; err_count increments by 1 and saturates at all-ones.

Optional Feature:
- Macro ISSUE_MON_CDB_FWD_EN.
- Defined: adds the following ports:
  - cdb_valid  in  N;
  - cdb_tag  in  N*PHYS_REG_IDX width;
  - rs_src1_tag and rs_src2_tag  in  RS_SZ*PHYS_REG_IDX width.
  - src_ok = ready bit OR (cdb_valid[k] && cdb_tag[k]==tag) for any k. Same-cycle CDB wakeup then counts as ready for both the not-ready and starvation checks.
- Undefined: src_ok = ready bit only, and these ports do not exist.

Decomposition:
- sys_defs package:
  - ISSUE_MON_STATE enum (OFF, RUN, FAULT);
  - err_code bit positions as localparam constants;
  - FU class encoding shared with the RS.
- One sub-module, issue_mon_age_ctr: a single saturating per-entry age counter that emits a one-shot starve pulse. It is instantiated RS_SZ times in a generate loop.

Test Plan:
- Reset mid-run: run with age[2]=30, pulse reset=0 -> all outputs 0 immediately, mon_state=00, and entry 2 needs a full 64 cycles to starve afterwards.
- Not-ready issue: enable=1, rs_valid[3]=1, src1=1, src2=0, rs_issuing[3]=1 -> next edge err_valid=1, err_code=001, err_index=3, err_count=1, mon_state=10.
- Oversubscription: three class-1 entries issuing, fu_free[1]=2 -> err_code=010, err_class=1; repeat with fu_free[1]=3 -> no error.
- Starvation: entry 5 valid and ready, never issued, STARVE_LIMIT=64 -> a single err_valid pulse with code 100 and index 5 exactly 64 cycles after readiness; flush at cycle 40 restarts the count.
- Fault clear: in FAULT, clear_err=1 with clean inputs -> RUN; clear_err=1 together with a new not-ready issue -> stays FAULT and err_count increments; preload err_count=16'hFFFF -> holds at 16'hFFFF.
- With ISSUE_MON_CDB_FWD_EN: src2_ready=0, rs_src2_tag=17, cdb_valid[0]=1, cdb_tag[0]=17, issuing -> no error; same stimulus with the macro undefined -> err_code=001.
